// File: rtl/multiword_add_seq.sv
// ---------------------------------------------------------------------------
// multiword_add_seq
//
// Multi-precision add/subtract sequencer. Operand word pairs arrive least
// significant first and go through a single 64-bit carry-lookahead adder, one
// word per cycle. The carry is chained from one word to the next. Subtract is
// computed as A + ~B + 1: B is inverted and the carry chain is seeded with 1.
// Each input word produces one registered result word. When the operation
// ends, the final carry and the signed overflow of the top word are held on
// the status outputs.
//
// Ports (multiword_add_seq):
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, op_sub, len  operation request (sampled in IDLE only); len = words-1
//   in_valid/in_ready   operand word pair handshake; data on in_a, in_b
//   out_valid/out_ready result word handshake; data on out_sum, out_last
//   busy                operation in progress (state != IDLE)
//   done                one-cycle completion pulse (FIN state)
//   carry_out           final carry (subtract: 1 = no borrow), held until start
//   overflow            signed overflow of the top word, held until start
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid and ready are both 1. A source that raises valid keeps valid and data
// stable until that transfer. ready may depend combinationally on valid.
// ---------------------------------------------------------------------------

// 64-bit two-level carry-lookahead adder.
// Level 1 groups 4 bits and level 2 groups 4 level-1 groups, so every carry is
// resolved through lookahead terms instead of a 64-stage ripple.
//   dina, dinb  addends
//   cin         carry in
//   sum, cout   result and carry out
module full_adder64 (
    input  logic [63:0] dina,
    input  logic [63:0] dinb,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    // Carries into positions 1..4 of a 4-wide block with carry-in ci.
    function automatic logic [3:0] la4(input logic [3:0] g, input logic [3:0] p,
                                       input logic ci);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Group generate of a 4-wide block.
    function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [63:0] g, p, c;
    logic [15:0] g1, p1, c1;
    logic [3:0]  g2, p2, c2, c2_hi;
    logic [3:0]  t;

    always_comb begin
        g     = dina & dinb;
        p     = dina ^ dinb;
        g1    = '0;
        p1    = '0;
        g2    = '0;
        p2    = '0;
        c1    = '0;
        c     = '0;
        t     = '0;

        for (int k = 0; k < 16; k++) begin
            g1[k] = grp_g(g[4*k +: 4], p[4*k +: 4]);
            p1[k] = &p[4*k +: 4];
        end
        for (int j = 0; j < 4; j++) begin
            g2[j] = grp_g(g1[4*j +: 4], p1[4*j +: 4]);
            p2[j] = &p1[4*j +: 4];
        end

        // c2[j] = carry into level-2 group j; c2_hi[3] is the adder carry out.
        c2_hi = la4(g2, p2, cin);
        c2    = {c2_hi[2:0], cin};

        for (int j = 0; j < 4; j++) begin
            t               = la4(g1[4*j +: 4], p1[4*j +: 4], c2[j]);
            c1[4*j]         = c2[j];
            c1[4*j+1 +: 3]  = t[2:0];
        end
        for (int k = 0; k < 16; k++) begin
            t              = la4(g[4*k +: 4], p[4*k +: 4], c1[k]);
            c[4*k]         = c1[k];
            c[4*k+1 +: 3]  = t[2:0];
        end

        sum  = p ^ c;
        cout = c2_hi[3];
    end

endmodule

module multiword_add_seq #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_sub,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              carry_out,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t             state;
    logic               op_sub_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic               carry_q;

    logic [DATA_W-1:0]  b_eff;
    logic [DATA_W-1:0]  add_sum;
    logic               add_cout;
    logic               in_fire;
    logic               out_fire;
    logic               last_word;
    logic               ovf_now;

    // Subtract feeds ~B. carry_q was seeded with 1 at start, which supplies
    // the +1 of the two's complement.
    assign b_eff = in_b ^ {DATA_W{op_sub_q}};

    full_adder64 u_add (
        .dina (in_a),
        .dinb (b_eff),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // There is only one output register and no skid buffer. A new word can
    // enter only if that register is empty or is being drained this cycle.
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_word = (cnt == len_q);

    // Signed overflow: both addends have the same sign and the sum sign differs.
    assign ovf_now = (in_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                     (add_sum[DATA_W-1] != in_a[DATA_W-1]);

    // busy and done are decoded directly from the state register.
    assign busy = (state != IDLE);
    assign done = (state == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_sub_q  <= 1'b0;
            len_q     <= '0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_sum   <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_sub_q  <= op_sub;
                        len_q     <= len;
                        carry_q   <= op_sub;
                        cnt       <= '0;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        // If a previous result is still in the register, it is
                        // being accepted this same cycle, so it can be overwritten.
                        out_sum   <= add_sum;
                        out_valid <= 1'b1;
                        out_last  <= last_word;
                        carry_q   <= add_cout;
                        cnt       <= cnt + LEN_W'(1);
                        if (last_word) begin
                            carry_out <= add_cout;
                            overflow  <= ovf_now;
                            state     <= DRAIN;
                        end
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// ---------------------------------------------------------------------------
// tb_multiword_add_seq
//
// Directed bench for multiword_add_seq. The bench drives inputs on the falling
// edge and samples outputs there as well, away from the active rising edge.
// Every expected value is computed by hand from the operands.
// ---------------------------------------------------------------------------
module tb_multiword_add_seq;

    localparam int DATA_W = 64;
    localparam int LEN_W  = 4;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              op_sub = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_sum;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              carry_out;
    logic              overflow;

    always #5 clk = ~clk;

    multiword_add_seq #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sub    (op_sub),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Request an operation. The task returns on a falling edge with the
    // sequencer in RUN.
    task automatic start_op(input logic sub, input logic [LEN_W-1:0] n);
        start  = 1'b1;
        op_sub = sub;
        len    = n;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Offer one word pair and wait, with a bound, for in_ready. The task
    // returns on the falling edge after the handshake, when the result is visible.
    task automatic send_word(input logic [63:0] a, input logic [63:0] b);
        int t;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        t        = 0;
        #1;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Check the result word against the oldest expected entry.
    task automatic chk_out(input string tag, input logic last);
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_sum"}, out_sum, e);
        chk({tag, "_last"}, 64'(out_last), 64'(last));
    endtask

    // After the last result is shown with out_ready=1: the handshake moves the
    // sequencer to FIN (done pulse), and the next edge returns it to IDLE.
    // A start raised during FIN must not be accepted.
    task automatic finish_op(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_fin"}, 64'(busy), 64'd1);
        chk({tag, "_outv_fin"}, 64'(out_valid), 64'd0);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timed out");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_carry_out", 64'(carry_out), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        // in_valid is ignored in IDLE
        in_valid = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;

        // T1: single-word add FFFF..FFFF + 1
        start_op(1'b0, 4'd0);
        exp_q.push_back(64'd0);
        send_word(ONES, 64'd1);
        chk_out("t1_w0", 1'b1);
        chk("t1_carry", 64'(carry_out), 64'd1);
        chk("t1_ovf", 64'(overflow), 64'd0);
        finish_op("t1");

        // T2: carry chain over two words
        start_op(1'b0, 4'd1);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        send_word(ONES, 64'd1);
        chk_out("t2_w0", 1'b0);
        send_word(64'd0, 64'd0);
        chk_out("t2_w1", 1'b1);
        chk("t2_carry", 64'(carry_out), 64'd0);
        chk("t2_ovf", 64'(overflow), 64'd0);
        finish_op("t2");

        // T3: subtract {1,0} - {0,1} = {0, FFFF..FFFF}, no borrow
        start_op(1'b1, 4'd1);
        exp_q.push_back(ONES);
        exp_q.push_back(64'd0);
        send_word(64'd0, 64'd1);
        chk_out("t3_w0", 1'b0);
        send_word(64'd1, 64'd0);
        chk_out("t3_w1", 1'b1);
        chk("t3_carry", 64'(carry_out), 64'd1);
        chk("t3_ovf", 64'(overflow), 64'd0);
        finish_op("t3");

        // T4: signed overflow 7FFF..FFFF + 1
        start_op(1'b0, 4'd0);
        exp_q.push_back(64'h8000_0000_0000_0000);
        send_word(64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk_out("t4_w0", 1'b1);
        chk("t4_ovf", 64'(overflow), 64'd1);
        chk("t4_carry", 64'(carry_out), 64'd0);
        finish_op("t4");

        // T5: 4 words with a 3-cycle output stall after the first result.
        //   w0: FFFF..FFFF + 1        = 0, carry 1
        //   w1: 5 + 6 + 1             = 12, carry 0
        //   w2: 10 + 20               = 30, carry 0
        //   w3: 8000.. + 8000..       = 0, carry 1, signed overflow
        start_op(1'b0, 4'd3);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd12);
        exp_q.push_back(64'd30);
        exp_q.push_back(64'd0);
        send_word(ONES, 64'd1);
        chk("t5_w0_sum_pre", out_sum, 64'd0);
        out_ready = 1'b0;
        start     = 1'b1;
        op_sub    = 1'b1;
        in_a      = 64'd5;
        in_b      = 64'd6;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall_in_ready", 64'(in_ready), 64'd0);
            chk("t5_stall_out_valid", 64'(out_valid), 64'd1);
            chk("t5_stall_out_sum", out_sum, 64'd0);
            chk("t5_stall_busy", 64'(busy), 64'd1);
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        op_sub    = 1'b0;
        out_ready = 1'b1;
        chk_out("t5_w0", 1'b0);
        send_word(64'd5, 64'd6);
        chk_out("t5_w1", 1'b0);
        send_word(64'd10, 64'd20);
        chk_out("t5_w2", 1'b0);
        send_word(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        chk_out("t5_w3", 1'b1);
        chk("t5_carry", 64'(carry_out), 64'd1);
        chk("t5_ovf", 64'(overflow), 64'd1);
        finish_op("t5");

        // T6: reset after 2 of 4 words, then a fresh 2 + 3
        start_op(1'b0, 4'd3);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        send_word(ONES, 64'd1);
        chk_out("t6_w0", 1'b0);
        send_word(ONES, 64'd1);
        chk_out("t6_w1", 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
        start_op(1'b0, 4'd0);
        exp_q.push_back(64'd5);
        send_word(64'd2, 64'd3);
        chk_out("t6_new", 1'b1);
        chk("t6_carry", 64'(carry_out), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
        finish_op("t6");

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
